// File: rtl/trace_pkg.sv
// Shared types and constants for the retirement trace capture FIFO.
// TRACE_TIMESTAMP_EN adds a 32-bit timestamp field to every trace record.
package trace_pkg;

   localparam int DEFAULT_DEPTH  = 16;
   localparam int DEFAULT_DROP_W = 16;

   localparam int FLAG_REG_WRITE = 0;
   localparam int FLAG_MEM_WRITE = 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [31:0] wdata;
      logic [1:0]  flags;
`ifdef TRACE_TIMESTAMP_EN
      logic [31:0] timestamp;
`endif
   } trace_rec_t;

endpackage

// File: rtl/trace_ram.sv
// Trace record storage: DEPTH entries, one synchronous write port, one combinational read port.
// Entries are not reset; only the pointers in the parent decide what is valid.
module trace_ram
   import trace_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                     clock,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  trace_rec_t               wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output trace_rec_t               rdata
);

   trace_rec_t mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture_fifo.sv
// Circular first-word-fall-through FIFO buffering per-cycle retirement records for a debug consumer.
// Optional macro TRACE_TIMESTAMP_EN adds a free-running cycle counter and the o_timestamp port.
module trace_capture_fifo
   import trace_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int DROP_W = DEFAULT_DROP_W
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     i_capture_en,
   input  logic [31:0]              i_pc,
   input  logic [31:0]              i_instr,
   input  logic [4:0]               i_rd,
   input  logic                     i_reg_write,
   input  logic                     i_mem_write,
   input  logic [31:0]              i_alu_result,
   input  logic                     i_drop_clear,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [31:0]              o_pc,
   output logic [31:0]              o_instr,
   output logic [4:0]               o_rd,
   output logic [31:0]              o_wdata,
   output logic [1:0]               o_flags,
`ifdef TRACE_TIMESTAMP_EN
   output logic [31:0]              o_timestamp,
`endif
   output logic [$clog2(DEPTH):0]   o_count,
   output logic [DROP_W-1:0]        o_dropped
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [DROP_W-1:0] dropped;

   logic       full;
   logic       pop;
   logic       accept;
   logic       drop;
   trace_rec_t wr_rec;
   trace_rec_t rd_rec;
   trace_rec_t head;

`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] cycle_count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cycle_count <= '0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
      end
   end
`endif

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign o_valid = (count != '0);
   assign full    = (count == CW'(DEPTH));
   assign pop     = o_valid & i_ready;
   assign accept  = i_capture_en & (~full | pop);
   assign drop    = i_capture_en & full & ~pop;

   always_comb begin
      wr_rec                       = '0;
      wr_rec.pc                    = i_pc;
      wr_rec.instr                 = i_instr;
      wr_rec.rd                    = i_rd;
      wr_rec.wdata                 = i_alu_result;
      wr_rec.flags[FLAG_REG_WRITE] = i_reg_write;
      wr_rec.flags[FLAG_MEM_WRITE] = i_mem_write;
`ifdef TRACE_TIMESTAMP_EN
      wr_rec.timestamp             = cycle_count;
`endif
   end

   trace_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clock (clock),
      .we    (accept),
      .waddr (wr_ptr),
      .wdata (wr_rec),
      .raddr (rd_ptr),
      .rdata (rd_rec)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Clear takes priority over a same-cycle drop; the counter sticks at all-ones.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dropped <= '0;
      end else if (i_drop_clear) begin
         dropped <= '0;
      end else if (drop && (dropped != {DROP_W{1'b1}})) begin
         dropped <= dropped + DROP_W'(1);
      end
   end

   assign head      = o_valid ? rd_rec : '0;
   assign o_pc      = head.pc;
   assign o_instr   = head.instr;
   assign o_rd      = head.rd;
   assign o_wdata   = head.wdata;
   assign o_flags   = head.flags;
`ifdef TRACE_TIMESTAMP_EN
   assign o_timestamp = head.timestamp;
`endif
   assign o_count   = count;
   assign o_dropped = dropped;

endmodule

// File: tb/tb_trace_capture_fifo.sv
// Directed bench for trace_capture_fifo (default build, DEPTH=16, DROP_W=16).
// Inputs change and outputs are checked on the falling clock edge.
module tb_trace_capture_fifo;

   logic        clock;
   logic        reset_n;
   logic        i_capture_en;
   logic [31:0] i_pc;
   logic [31:0] i_instr;
   logic [4:0]  i_rd;
   logic        i_reg_write;
   logic        i_mem_write;
   logic [31:0] i_alu_result;
   logic        i_drop_clear;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_pc;
   logic [31:0] o_instr;
   logic [4:0]  o_rd;
   logic [31:0] o_wdata;
   logic [1:0]  o_flags;
   logic [4:0]  o_count;
   logic [15:0] o_dropped;

   int compared = 0;
   int mismatched = 0;

   trace_capture_fifo #(
      .DEPTH  (16),
      .DROP_W (16)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_capture_en (i_capture_en),
      .i_pc         (i_pc),
      .i_instr      (i_instr),
      .i_rd         (i_rd),
      .i_reg_write  (i_reg_write),
      .i_mem_write  (i_mem_write),
      .i_alu_result (i_alu_result),
      .i_drop_clear (i_drop_clear),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_pc         (o_pc),
      .o_instr      (o_instr),
      .o_rd         (o_rd),
      .o_wdata      (o_wdata),
      .o_flags      (o_flags),
      .o_count      (o_count),
      .o_dropped    (o_dropped)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Record contents are a pure function of an index; index 0 is the reference addi record.
   function automatic logic [31:0] recPc(input int idx);
      return 32'h0040_0000 + 32'(4 * idx);
   endfunction

   function automatic logic [31:0] recInstr(input int idx);
      return 32'h0050_0093 + (32'(idx) << 20);
   endfunction

   function automatic logic [4:0] recRd(input int idx);
      return 5'(idx + 1);
   endfunction

   function automatic logic [31:0] recAlu(input int idx);
      return 32'(5 + 3 * idx);
   endfunction

   function automatic logic [1:0] recFlags(input int idx);
      logic [31:0] v;
      v = 32'(idx);
      return {v[1], ~v[0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drives one cycle of inputs, then waits for the next falling edge.
   task automatic applyStimulus(input bit cap, input int idx, input bit rdy, input bit clr);
      logic [1:0] f;
      f            = recFlags(idx);
      i_capture_en = cap;
      i_pc         = recPc(idx);
      i_instr      = recInstr(idx);
      i_rd         = recRd(idx);
      i_alu_result = recAlu(idx);
      i_reg_write  = f[0];
      i_mem_write  = f[1];
      i_ready      = rdy;
      i_drop_clear = clr;
      @(negedge clock);
   endtask

   task automatic checkHead(input string tag, input int idx);
      checkOutput({tag, " valid"}, 64'(o_valid), 64'd1);
      checkOutput({tag, " pc"},    64'(o_pc),    64'(recPc(idx)));
      checkOutput({tag, " flags"}, 64'(o_flags), 64'(recFlags(idx)));
   endtask

   initial begin
      reset_n      = 1'b0;
      i_capture_en = 1'b0;
      i_pc         = '0;
      i_instr      = '0;
      i_rd         = '0;
      i_reg_write  = 1'b0;
      i_mem_write  = 1'b0;
      i_alu_result = '0;
      i_drop_clear = 1'b0;
      i_ready      = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // Idle after reset
      checkOutput("idle valid",   64'(o_valid),   64'd0);
      checkOutput("idle count",   64'(o_count),   64'd0);
      checkOutput("idle dropped", 64'(o_dropped), 64'd0);
      checkOutput("idle pc",      64'(o_pc),      64'd0);
      checkOutput("idle instr",   64'(o_instr),   64'd0);
      checkOutput("idle rd",      64'(o_rd),      64'd0);
      checkOutput("idle wdata",   64'(o_wdata),   64'd0);
      checkOutput("idle flags",   64'(o_flags),   64'd0);

      // Single push held under backpressure
      applyStimulus(1, 0, 0, 0);
      i_capture_en = 1'b0;
      checkOutput("single valid", 64'(o_valid), 64'd1);
      checkOutput("single pc",    64'(o_pc),    64'h0040_0000);
      checkOutput("single instr", 64'(o_instr), 64'h0050_0093);
      checkOutput("single rd",    64'(o_rd),    64'd1);
      checkOutput("single wdata", 64'(o_wdata), 64'd5);
      checkOutput("single flags", 64'(o_flags), 64'b01);
      checkOutput("single count", 64'(o_count), 64'd1);
      for (int c = 0; c < 10; c++) begin
         applyStimulus(0, 0, 0, 0);
         checkOutput("hold valid", 64'(o_valid), 64'd1);
         checkOutput("hold pc",    64'(o_pc),    64'h0040_0000);
         checkOutput("hold wdata", 64'(o_wdata), 64'd5);
      end
      applyStimulus(0, 0, 1, 0);
      checkOutput("drain1 valid", 64'(o_valid), 64'd0);
      checkOutput("drain1 count", 64'(o_count), 64'd0);
      checkOutput("drain1 pc",    64'(o_pc),    64'd0);

      // Overfill: 20 pushes into 16 entries
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, i, 0, 0);
      end
      checkOutput("fill count",   64'(o_count),   64'd16);
      checkOutput("fill dropped", 64'(o_dropped), 64'd4);
      checkHead("fill head", 0);

      // Push and pop together while full
      applyStimulus(1, 100, 1, 0);
      checkOutput("fullpp count",   64'(o_count),   64'd16);
      checkOutput("fullpp dropped", 64'(o_dropped), 64'd4);
      for (int k = 1; k < 16; k++) begin
         checkHead("drain2", k);
         checkOutput("drain2 rd", 64'(o_rd), 64'(recRd(k)));
         applyStimulus(0, 0, 1, 0);
      end
      checkHead("drain2 last", 100);
      checkOutput("drain2 last wdata", 64'(o_wdata), 64'(recAlu(100)));
      applyStimulus(0, 0, 1, 0);
      checkOutput("drain2 valid", 64'(o_valid), 64'd0);
      checkOutput("drain2 count", 64'(o_count), 64'd0);

      // Drop clear beats a same-cycle drop
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1, 32 + i, 0, 0);
      end
      checkOutput("refill count",   64'(o_count),   64'd16);
      checkOutput("refill dropped", 64'(o_dropped), 64'd4);
      applyStimulus(1, 60, 0, 1);
      checkOutput("clrdrop dropped", 64'(o_dropped), 64'd0);
      applyStimulus(1, 61, 0, 0);
      checkOutput("drop after clr", 64'(o_dropped), 64'd1);
      applyStimulus(0, 0, 0, 1);
      checkOutput("clr only",       64'(o_dropped), 64'd0);
      checkOutput("clr count",      64'(o_count),   64'd16);

      // Asynchronous reset in the middle of a drain
      for (int i = 0; i < 9; i++) begin
         applyStimulus(0, 0, 1, 0);
      end
      i_ready = 1'b0;
      checkOutput("predrst count", 64'(o_count), 64'd7);
      checkHead("predrst head", 41);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("arst valid", 64'(o_valid), 64'd0);
      checkOutput("arst count", 64'(o_count), 64'd0);
      checkOutput("arst pc",    64'(o_pc),    64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      checkOutput("postrst valid", 64'(o_valid), 64'd0);
      checkOutput("postrst count", 64'(o_count), 64'd0);
      applyStimulus(1, 50, 0, 0);
      i_capture_en = 1'b0;
      checkHead("postrst push", 50);
      checkOutput("postrst push count", 64'(o_count), 64'd1);
      checkOutput("postrst dropped",    64'(o_dropped), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/trace_capture_fifo.md
Name: trace_capture_fifo

Overview:
- Sits directly downstream of the single-cycle RISC-V datapath top.
- Samples the per-cycle retirement signals: PC, instruction, rd, ALU result, RegWrite, MemWrite.
- Buffers each sample as one trace record in a circular FIFO.
- Drains records to a debug consumer (UART or JTAG bridge) over a valid/ready stream.
- Counts records dropped while the FIFO is full.

Parameters:
- DEPTH, 16, number of trace records; power of two, minimum 2.
- DROP_W, 16, width of the saturating dropped-record counter.

Ports:
- clock  in  1  system clock; the same clock that drives the datapath.
- reset_n  in  1  asynchronous active-low reset.
- i_capture_en  in  1  when high, one record is offered every cycle.
- i_pc  in  32  PC of the retiring instruction.
- i_instr  in  32  retiring instruction word.
- i_rd  in  5  destination register index.
- i_reg_write  in  1  RegWrite control of the retiring instruction.
- i_mem_write  in  1  MemWrite control of the retiring instruction.
- i_alu_result  in  32  ALU result of the retiring instruction.
- i_drop_clear  in  1  synchronous clear of o_dropped.
- o_valid  out  1  a head record is presented.
- i_ready  in  1  consumer accepts the head record.
- o_pc  out  32  head record PC.
- o_instr  out  32  head record instruction.
- o_rd  out  5  head record rd.
- o_wdata  out  32  head record ALU result.
- o_flags  out  2  head record flags: {mem_write, reg_write}.
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_dropped  out  DROP_W  saturating count of dropped records.

Behaviour:
- Reset is asynchronous and active-low; the design has one clock.
- Asserting reset_n low immediately forces: write pointer, read pointer and count to 0, o_valid=0, o_dropped=0, o_count=0.
- Reset clears storage pointers only; storage contents are don't-care.
- o_pc/o_instr/o_rd/o_wdata/o_flags read 0 after reset and whenever o_valid=0.
- push = i_capture_en.
- pop = o_valid & i_ready.
- Output is first-word-fall-through from storage, indexed by the read pointer.
- Latency: a record pushed at rising edge N is presented with o_valid=1 in the cycle after edge N. Empty-to-valid latency is 1 cycle.
- Accept rule: push is accepted if count<DEPTH, or if count==DEPTH and pop occurs in the same cycle. An accepted push writes at the write pointer, which then increments.
- Rejected push (full and no pop): record discarded; o_dropped increments, saturating at 2^DROP_W-1.
- Simultaneous push and pop: both performed and count unchanged. This includes the full case, where no drop occurs.
- Pop while empty is impossible because o_valid=0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is tracked separately to distinguish full from empty.
- o_valid and the head fields must stay stable while o_valid=1 and i_ready=0. Consumer must see no change until the handshake completes.
- i_drop_clear: o_dropped goes to 0 on the next edge. If a drop occurs in the same cycle, the clear wins and the result is 0.
- Deasserting i_capture_en mid-stream stops pushes immediately; already buffered records continue to drain.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- When defined:
  - A 32-bit free-running cycle counter is added; reset value 0, wraps at 2^32.
  - Each record stores the counter value sampled at its push edge.
  - Extra port o_timestamp (out, 32) presents the head record's timestamp; 0 when o_valid=0.
- When undefined: no counter, no storage field, no o_timestamp port. All other behaviour is identical.

Decomposition:
- Shared package trace_pkg holds:
  - trace record typedef: pc, instr, rd, wdata, flags, plus the timestamp field under the macro.
  - flag bit position constants: FLAG_REG_WRITE=0, FLAG_MEM_WRITE=1.
  - default DEPTH and DROP_W constants.
- One natural sub-module, trace_ram: DEPTH x record-width storage with a synchronous write port and a combinational read port. The top keeps pointers, count, drop counter and handshake.

Test Plan:
- Reset then idle, i_capture_en=0 -> o_valid=0, o_count=0, o_dropped=0, all head fields 0.
- Single push of pc=0x00400000, instr=0x00500093, rd=1, reg_write=1, alu=5, with i_ready=0 -> next cycle o_valid=1, o_pc=0x00400000, o_flags=2'b01, o_count=1; values held for 10 cycles.
- 20 consecutive pushes with i_ready=0 and DEPTH=16 -> o_count=16, o_dropped=4; draining returns the first 16 records in order.
- At full, push and pop in the same cycle -> o_count stays 16, o_dropped unchanged, and the new record appears last after draining.
- Drop with i_drop_clear asserted in the same cycle -> o_dropped=0 next cycle.
- reset_n pulsed low mid-drain at count=7 -> o_valid falls without waiting for a clock edge; after release, o_count=0 and a new push is seen 1 cycle later. With TRACE_TIMESTAMP_EN, the first post-reset record pushed at cycle 3 shows o_timestamp=3.
